bpu_gshare_param: RTL and testbench
===================================

// Module: bpu_gshare_param
// PURPOSE
//  Parametrised two-level branch predictor for the pipelined RV32I core.
//  - Fetch: combinational taken/not-taken prediction from a pattern history
//    table (PHT) of saturating counters. The PHT index is formed from PCF and a
//    global history register (GHR) in one of three modes.
//  - Branch stage: the resolved outcome trains the PHT entry that produced the
//    prediction, shifts the GHR, and updates the branch/mispredict counters.
// PARAMETERS
//  IDX_WIDTH  default 6  PHT index width; PHT has 2**IDX_WIDTH entries.
//  GHR_WIDTH  default 4  Global history length.
//                        Must be <= IDX_WIDTH (MODE 0/1); < IDX_WIDTH (MODE 2).
//  CTR_BITS   default 2  Counter width per PHT entry (2..4).
//  MODE       default 1  Index function: 0 = global, 1 = gshare (XOR), 2 = concat.
// PORTS
//  clk       in   1          Core clock; all state updates on its rising edge.
//  reset     in   1          Asynchronous, active-low reset.
//  PCF       in   32         Fetch-stage PC.
//  BP        out  1          Prediction for PCF; 1 = taken.
//  BPIdxF    out  IDX_WIDTH  PHT index used for BP. Carried down the pipe to IdxB.
//  BranchB   in   1          Branch-stage instruction is a conditional branch (update strobe).
//  TakenB    in   1          Resolved outcome; 1 = taken.
//  PredB     in   1          Prediction originally made for this branch (BP carried down).
//  IdxB      in   IDX_WIDTH  PHT index originally used (BPIdxF carried down).
//  GHR       out  GHR_WIDTH  Current global history; bit 0 = most recent outcome.
//  BranchCnt out  32         Number of updates since reset.
//  MissCnt   out  32         Number of mispredictions since reset.
// BEHAVIOUR
//  Index, with PCI = PCF[IDX_WIDTH+1:2]:
//  - MODE 0: zero-extended GHR.
//  - MODE 1: PCI ^ zero-extended GHR.
//  - MODE 2: {GHR, PCF[IDX_WIDTH-GHR_WIDTH+1:2]}.
//  Prediction:
//  - BP = MSB of PHT[BPIdxF]. BPIdxF and BP are purely combinational; zero latency.
//  Reset (reset=0, async assert, sync-to-clk release):
//  - Every PHT entry = weakly-not-taken, i.e. 2**(CTR_BITS-1)-1 (2'b01 for CTR_BITS=2).
//  - GHR = 0; BranchCnt = 0; MissCnt = 0.
//  - BP = 0 during reset.
//  Update (rising edge with BranchB=1):
//  - PHT[IdxB]: +1 if TakenB, -1 otherwise. Saturates at 2**CTR_BITS-1 and at 0; never wraps.
//  - GHR <= {GHR[GHR_WIDTH-2:0], TakenB}. Non-speculative: only resolved
//    outcomes enter the GHR.
//  - BranchCnt += 1.
//  - MissCnt += 1 when PredB != TakenB.
//  - Both counters saturate at 32'hFFFF_FFFF.
//  BranchB=0: no state changes. TakenB, PredB and IdxB are ignored.
//  Read/update collision:
//  - If BPIdxF == IdxB in an update cycle, BP uses the pre-update counter (no bypass).
//  - The GHR change affects BPIdxF from the next cycle only.
//  Reset mid-operation:
//  - Asserting reset at any time restores every reset value immediately.
//  - No partial update may survive; an update on the release edge is dropped.
//  - Only PHT[IdxB] changes per update; all other entries hold.
// TESTING
//  1. Reset defaults: after reset, any PCF -> BP=0, GHR=0, BranchCnt=0, MissCnt=0.
//  2. Saturation (CTR_BITS=2, MODE 0, GHR held 0):
//     - 3 taken updates on IdxB=0 -> counter 3, BP=1.
//     - 4th taken -> stays 3.
//     - 4 not-taken -> 0; 5th -> stays 0.
//  3. gshare index: MODE 1, GHR=4'b1010, PCF=32'h0000_0040 -> BPIdxF=6'h1A.
//     - Shifting in TakenB=1 gives GHR=4'b0101 -> BPIdxF=6'h15.
//  4. Collision: BPIdxF==IdxB=5, counter=1, taken update -> BP=0 that cycle, BP=1 next cycle.
//  5. Counters: 10 updates, PredB!=TakenB on 3 of them -> BranchCnt=10, MissCnt=3.
//     - 4 cycles with BranchB=0 -> both counters unchanged.
//  6. Async reset: after training PHT[7] to 3, GHR=4'hF:
//     - Pulse reset low mid-cycle -> immediate BP=0, GHR=0, counters=0.
//     - Concurrent BranchB on the release edge has no effect.

Source files
------------

// File: rtl/bpu_gshare_param.sv
// Two-level branch predictor: a PHT of saturating counters indexed by PC and global history,
// read combinationally at fetch and trained by resolved outcomes from the branch stage.
module bpu_gshare_param #(
    parameter int IDX_WIDTH = 6,
    parameter int GHR_WIDTH = 4,
    parameter int CTR_BITS  = 2,
    parameter int MODE      = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          PCF,
    output logic                 BP,
    output logic [IDX_WIDTH-1:0] BPIdxF,
    input  logic                 BranchB,
    input  logic                 TakenB,
    input  logic                 PredB,
    input  logic [IDX_WIDTH-1:0] IdxB,
    output logic [GHR_WIDTH-1:0] GHR,
    output logic [31:0]          BranchCnt,
    output logic [31:0]          MissCnt
);

    localparam int ENTRIES = 2 ** IDX_WIDTH;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic [CTR_BITS-1:0]  pht_q [ENTRIES];
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic [31:0]          branch_cnt_q, branch_cnt_d;
    logic [31:0]          miss_cnt_q, miss_cnt_d;
    logic [CTR_BITS-1:0]  ctr_d;
    logic                 armed_q;
    logic                 upd;
    logic                 unused_pcf;

    assign unused_pcf = ^PCF;

    generate
        if (MODE == 0) begin : g_global
            assign BPIdxF = IDX_WIDTH'(ghr_q);
        end else if (MODE == 1) begin : g_gshare
            assign BPIdxF = PCF[IDX_WIDTH+1:2] ^ IDX_WIDTH'(ghr_q);
        end else begin : g_concat
            assign BPIdxF = {ghr_q, PCF[IDX_WIDTH-GHR_WIDTH+1:2]};
        end
    endgenerate

    // No bypass: a same-cycle update to the read entry is seen only after the edge.
    assign BP        = reset & pht_q[BPIdxF][CTR_BITS-1];
    assign GHR       = ghr_q;
    assign BranchCnt = branch_cnt_q;
    assign MissCnt   = miss_cnt_q;

    // armed_q stays low for the first edge after reset release so that edge cannot update.
    assign upd = BranchB & armed_q;

    always_comb begin
        ctr_d = pht_q[IdxB];
        if (TakenB) begin
            if (ctr_d != CTR_MAX) ctr_d = ctr_d + CTR_BITS'(1);
        end else begin
            if (ctr_d != '0) ctr_d = ctr_d - CTR_BITS'(1);
        end
        ghr_d        = GHR_WIDTH'({ghr_q, TakenB});
        branch_cnt_d = (branch_cnt_q == '1) ? branch_cnt_q : branch_cnt_q + 32'd1;
        miss_cnt_d   = ((PredB != TakenB) && (miss_cnt_q != '1)) ? miss_cnt_q + 32'd1
                                                                 : miss_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_q      <= 1'b0;
            ghr_q        <= '0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) pht_q[i] <= CTR_INIT;
        end else begin
            armed_q <= 1'b1;
            if (upd) begin
                pht_q[IdxB]  <= ctr_d;
                ghr_q        <= ghr_d;
                branch_cnt_q <= branch_cnt_d;
                miss_cnt_q   <= miss_cnt_d;
            end
        end
    end

endmodule

// File: tb/tb_bpu_gshare_param.sv
// Bench for bpu_gshare_param (default parameters: 64-entry PHT, 4-bit GHR, 2-bit counters, gshare),
// checked against an array/integer model of the predictor.
module tb_bpu_gshare_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic        BP;
    logic [5:0]  BPIdxF;
    logic        BranchB, TakenB, PredB;
    logic [5:0]  IdxB;
    logic [3:0]  GHR;
    logic [31:0] BranchCnt, MissCnt;

    int n_chk  = 0;
    int n_pass = 0;

    int     m_pht [64];
    int     m_ghr;
    longint m_br, m_miss;

    bpu_gshare_param dut (
        .clk(clk), .reset(reset), .PCF(PCF), .BP(BP), .BPIdxF(BPIdxF),
        .BranchB(BranchB), .TakenB(TakenB), .PredB(PredB), .IdxB(IdxB),
        .GHR(GHR), .BranchCnt(BranchCnt), .MissCnt(MissCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_pht[i] = 1;
        m_ghr  = 0;
        m_br   = 0;
        m_miss = 0;
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return ((pc >> 2) & 63) ^ m_ghr;
    endfunction

    // Called at posedge+1: sets inputs, then checks the combinational view against the model.
    task automatic drive(input logic br, input logic tk, input logic pd,
                         input logic [5:0] idx, input logic [31:0] pc);
        int e;
        PCF = pc; BranchB = br; TakenB = tk; PredB = pd; IdxB = idx;
        #1;
        e = m_idx(pc);
        chk("idx",   32'(BPIdxF), 32'(e));
        chk("bp",    32'(BP), (m_pht[e] >= 2) ? 32'd1 : 32'd0);
        chk("ghr",   32'(GHR), 32'(m_ghr));
        chk("brcnt", BranchCnt, 32'(m_br));
        chk("miss",  MissCnt, 32'(m_miss));
    endtask

    task automatic tick();
        @(posedge clk);
        if (BranchB) begin
            if (TakenB) m_pht[IdxB] = (m_pht[IdxB] == 3) ? 3 : m_pht[IdxB] + 1;
            else        m_pht[IdxB] = (m_pht[IdxB] == 0) ? 0 : m_pht[IdxB] - 1;
            m_ghr = ((m_ghr << 1) | int'(TakenB)) & 15;
            m_br++;
            if (PredB != TakenB) m_miss++;
        end
        #1;
    endtask

    task automatic cycle(input logic br, input logic tk, input logic pd,
                         input logic [5:0] idx, input logic [31:0] pc);
        drive(br, tk, pd, idx, pc);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0; BranchB = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; PCF = '0; BranchB = 0; TakenB = 0; PredB = 0; IdxB = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        // reset defaults across a few PCs
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 6'd0, $urandom);
            chk("rst_bp", 32'(BP), 32'd0);
            chk("rst_ghr", 32'(GHR), 32'd0);
            chk("rst_cnt", BranchCnt | MissCnt, 32'd0);
            tick();
        end

        // saturation on entry 0, always reading entry 0 through the current history
        for (int i = 0; i < 4; i++) cycle(1, 1, 1, 6'd0, 32'(m_ghr) << 2);
        drive(0, 0, 0, 6'd0, 32'(m_ghr) << 2);
        chk("sat_hi_bp", 32'(BP), 32'd1);
        tick();
        cycle(1, 0, 1, 6'd0, 32'(m_ghr) << 2);
        drive(0, 0, 0, 6'd0, 32'(m_ghr) << 2);
        chk("sat_hi_hold", 32'(BP), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 6'd0, 32'(m_ghr) << 2);
        cycle(1, 1, 0, 6'd0, 32'(m_ghr) << 2);
        drive(0, 0, 0, 6'd0, 32'(m_ghr) << 2);
        chk("sat_lo_hold", 32'(BP), 32'd0);
        tick();

        // gshare index
        do_reset();
        cycle(1, 1, 1, 6'd63, 32'h0);
        cycle(1, 0, 0, 6'd63, 32'h0);
        cycle(1, 1, 1, 6'd63, 32'h0);
        cycle(1, 0, 0, 6'd63, 32'h0);
        drive(1, 1, 1, 6'd62, 32'h0000_0040);
        chk("gshare_ghr", 32'(GHR), 32'hA);
        chk("gshare_idx", 32'(BPIdxF), 32'h1A);
        tick();
        drive(0, 0, 0, 6'd0, 32'h0000_0040);
        chk("gshare_ghr2", 32'(GHR), 32'h5);
        chk("gshare_idx2", 32'(BPIdxF), 32'h15);
        tick();

        // read/update collision on entry 5
        drive(1, 1, 0, 6'd5, 32'(5 ^ m_ghr) << 2);
        chk("coll_idx", 32'(BPIdxF), 32'd5);
        chk("coll_bp_now", 32'(BP), 32'd0);
        tick();
        drive(0, 0, 0, 6'd0, 32'(5 ^ m_ghr) << 2);
        chk("coll_bp_next", 32'(BP), 32'd1);
        tick();

        // branch / mispredict counters
        do_reset();
        for (int i = 0; i < 10; i++) begin
            logic tk;
            tk = 1'($urandom);
            cycle(1, tk, tk ^ (i == 2 || i == 5 || i == 8), 6'($urandom), $urandom);
        end
        drive(0, 0, 0, 6'd0, $urandom);
        chk("cnt_br10", BranchCnt, 32'd10);
        chk("cnt_miss3", MissCnt, 32'd3);
        tick();
        for (int i = 0; i < 4; i++) cycle(0, 1'($urandom), 1'($urandom), 6'($urandom), $urandom);
        chk("cnt_br_idle", BranchCnt, 32'd10);
        chk("cnt_miss_idle", MissCnt, 32'd3);

        // async reset mid-cycle, release edge update dropped
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 6'd7, 32'h0);
        drive(0, 0, 0, 6'd0, 32'(7 ^ m_ghr) << 2);
        chk("pre_rst_bp", 32'(BP), 32'd1);
        chk("pre_rst_ghr", 32'(GHR), 32'hF);
        #2 reset = 1'b0;
        #1;
        m_reset();
        chk("arst_bp", 32'(BP), 32'd0);
        chk("arst_ghr", 32'(GHR), 32'd0);
        chk("arst_br", BranchCnt, 32'd0);
        chk("arst_miss", MissCnt, 32'd0);
        PCF = 32'd7 << 2; BranchB = 1; TakenB = 1; PredB = 0; IdxB = 6'd7;
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ghr", 32'(GHR), 32'd0);
        chk("rel_br", BranchCnt, 32'd0);
        chk("rel_miss", MissCnt, 32'd0);
        chk("rel_bp", 32'(BP), 32'd0);
        cycle(1, 1, 0, 6'd7, 32'd7 << 2);
        drive(0, 0, 0, 6'd0, 32'(7 ^ m_ghr) << 2);
        chk("rel_train_bp", 32'(BP), 32'd1);
        tick();

        // random traffic; predictions sometimes taken from the DUT's own BP path via the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            logic tk, pd;
            pc = $urandom;
            tk = 1'($urandom);
            pd = ($urandom_range(0, 3) == 0) ? 1'($urandom) : ((m_pht[m_idx(pc)] >= 2) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 3) == 0)
                cycle(1, tk, pd, 6'(m_idx(pc)), pc);
            else
                cycle(1'($urandom), tk, pd, 6'($urandom), pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
